// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding, reset PC,
// MIPS instruction field positions and the opcodes the control decoder also uses.
package ifetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_VALID = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 26;
    localparam int RS_HI     = 25;
    localparam int RS_LO     = 21;
    localparam int RT_HI     = 20;
    localparam int RT_LO     = 16;
    localparam int RD_HI     = 15;
    localparam int RD_LO     = 11;
    localparam int SHAMT_HI  = 10;
    localparam int SHAMT_LO  = 6;
    localparam int FUNCT_HI  = 5;
    localparam int FUNCT_LO  = 0;
    localparam int IMM_HI    = 15;
    localparam int IMM_LO    = 0;
    localparam int JIDX_HI   = 25;
    localparam int JIDX_LO   = 0;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;

    // Word-scaled, sign-extended branch displacement.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_unit_npc_sel.sv
// Next-PC selection: jump beats taken branch beats fall-through, result word aligned.
module npc_sel
    import ifetch_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc_plus4,
    input  logic [31:0]       instr,
    input  logic              jump,
    input  logic              branch,
    input  logic              zero,
    output logic [ADDR_W-1:0] next_pc
);

    logic [ADDR_W-1:0] jumpTarget;
    logic [ADDR_W-1:0] branchTarget;
    logic [ADDR_W-1:0] selPc;
    logic              unusedOpcode;

    assign jumpTarget   = ADDR_W'({pc_plus4[ADDR_W-1 -: 4], instr[JIDX_HI:JIDX_LO], 2'b00});
    assign branchTarget = pc_plus4 + ADDR_W'(branch_offset(instr[IMM_HI:IMM_LO]));
    assign unusedOpcode = ^instr[OPCODE_HI:OPCODE_LO];

    always_comb begin
        selPc = pc_plus4;
        if (jump) begin
            selPc = jumpTarget;
        end else if (branch && zero) begin
            selPc = branchTarget;
        end
    end

    assign next_pc = selPc & ~ADDR_W'(3);

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: PC register, instruction register and the
// IDLE/REQ/VALID handshake FSM toward instruction memory.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic [31:0]       instr,
    output logic [5:0]        opcode,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [4:0]        shamt,
    output logic [5:0]        funct,
    output logic [15:0]       imm16,
    output logic              instr_valid,
    input  logic              instr_done,
    input  logic              jump,
    input  logic              branch,
    input  logic              zero
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] nextPc;

    npc_sel #(
        .ADDR_W (ADDR_W)
    ) u_npc_sel (
        .pc_plus4 (pc_plus4),
        .instr    (instr_q),
        .jump     (jump),
        .branch   (branch),
        .zero     (zero),
        .next_pc  (nextPc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // Each input is only honoured in the one state that expects it.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = ST_VALID;
                end
            end
            ST_VALID: begin
                if (instr_done) begin
                    pc_d    = nextPc;
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Decoded from state so a reset drops the request without waiting for a clock.
    assign imem_req    = (state_q == ST_REQ);
    assign instr_valid = (state_q == ST_VALID);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + ADDR_W'(4);
    assign instr       = instr_q;

    assign opcode = instr_q[OPCODE_HI:OPCODE_LO];
    assign rs     = instr_q[RS_HI:RS_LO];
    assign rt     = instr_q[RT_HI:RT_LO];
    assign rd     = instr_q[RD_HI:RD_LO];
    assign shamt  = instr_q[SHAMT_HI:SHAMT_LO];
    assign funct  = instr_q[FUNCT_HI:FUNCT_LO];
    assign imm16  = instr_q[IMM_HI:IMM_LO];

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: reset, table-driven fetch/redirect sequence,
// and hand-written async-reset-during-request sequence.
module tb_ifetch_unit;

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        done;
        logic        jmp;
        logic        br;
        logic        zr;
        logic        expReq;
        logic        expValid;
        logic [31:0] expPc;
        logic [31:0] expInstr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic        instr_valid;
    logic        instr_done = 1'b0;
    logic        jump = 1'b0;
    logic        branch = 1'b0;
    logic        zero = 1'b0;

    int checks = 0;
    int failures = 0;
    vec_t vecs[$];

    ifetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .instr       (instr),
        .opcode      (opcode),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .shamt       (shamt),
        .funct       (funct),
        .imm16       (imm16),
        .instr_valid (instr_valid),
        .instr_done  (instr_done),
        .jump        (jump),
        .branch      (branch),
        .zero        (zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ack, input logic [31:0] rdata, input logic done,
                                 input logic jmp, input logic br, input logic zr);
        imem_ack   = ack;
        imem_rdata = rdata;
        instr_done = done;
        jump       = jmp;
        branch     = br;
        zero       = zr;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic addVec(input logic ack, input logic [31:0] rdata, input logic done,
                          input logic jmp, input logic br, input logic zr,
                          input logic expReq, input logic expValid,
                          input logic [31:0] expPc, input logic [31:0] expInstr);
        vecs.push_back('{ack, rdata, done, jmp, br, zr, expReq, expValid, expPc, expInstr});
    endtask

    initial begin
        // Row = inputs for one cycle, then expected state after the edge.
        //     ack   rdata         done  jmp   br    zr    req   valid pc             instr
        addVec(1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_3004, 32'h3C01_1001);
        addVec(1'b1, 32'h2001_0005,1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3004, 32'h2001_0005);
        addVec(1'b1, 32'hDEAD_BEEF,1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3004, 32'h2001_0005);
        addVec(1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_3008, 32'h2001_0005);
        addVec(1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_3008, 32'h2001_0005);
        addVec(1'b1, 32'h1000_FFFF,1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3008, 32'h1000_FFFF);
        addVec(1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_3008, 32'h1000_FFFF);
        addVec(1'b1, 32'h1000_FFFF,1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3008, 32'h1000_FFFF);
        addVec(1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_300C, 32'h1000_FFFF);
        addVec(1'b1, 32'h0000_0000,1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_300C, 32'h0000_0000);
        addVec(1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_3010, 32'h0000_0000);
        addVec(1'b1, 32'h0800_0C00,1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3010, 32'h0800_0C00);
        addVec(1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_3000, 32'h0800_0C00);
        addVec(1'b1, 32'h0800_0C00,1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3000, 32'h0800_0C00);
        addVec(1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_3000, 32'h0800_0C00);
        addVec(1'b0, 32'h1111_1111,1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_3000, 32'h0800_0C00);
        addVec(1'b0, 32'h2222_2222,1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_3000, 32'h0800_0C00);
        addVec(1'b0, 32'h3333_3333,1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_3000, 32'h0800_0C00);
        addVec(1'b1, 32'h1000_8000,1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3000, 32'h1000_8000);
        addVec(1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hFFFE_3004, 32'h1000_8000);
        addVec(1'b1, 32'h0BFF_FFFF,1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFE_3004, 32'h0BFF_FFFF);
        addVec(1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0BFF_FFFF);
        addVec(1'b1, 32'h0000_0000,1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0000_0000);
        addVec(1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000);
        addVec(1'b1, 32'h1000_FFFF,1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h1000_FFFF);
        addVec(1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 32'h1000_FFFF);

        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("reset.req", 32'(imem_req), 32'h0);
        checkOutput("reset.valid", 32'(instr_valid), 32'h0);
        checkOutput("reset.pc", pc, 32'h0000_3000);
        checkOutput("reset.pc_plus4", pc_plus4, 32'h0000_3004);
        checkOutput("reset.instr", instr, 32'h0);
        checkOutput("reset.opcode", 32'(opcode), 32'h0);

        rst = 1'b0;
        checkOutput("idle.req", 32'(imem_req), 32'h0);
        tick();
        checkOutput("first.req", 32'(imem_req), 32'h1);
        checkOutput("first.addr", imem_addr, 32'h0000_3000);
        checkOutput("first.valid", 32'(instr_valid), 32'h0);

        applyStimulus(1'b1, 32'h3C01_1001, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("first.valid_after_ack", 32'(instr_valid), 32'h1);
        checkOutput("first.req_after_ack", 32'(imem_req), 32'h0);
        checkOutput("first.opcode", 32'(opcode), 32'h0F);
        checkOutput("first.rs", 32'(rs), 32'h0);
        checkOutput("first.rt", 32'(rt), 32'h1);
        checkOutput("first.rd", 32'(rd), 32'h2);
        checkOutput("first.shamt", 32'(shamt), 32'h0);
        checkOutput("first.funct", 32'(funct), 32'h01);
        checkOutput("first.imm16", 32'(imm16), 32'h1001);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].ack, vecs[i].rdata, vecs[i].done, vecs[i].jmp, vecs[i].br, vecs[i].zr);
            tick();
            checkOutput($sformatf("v%0d.req", i), 32'(imem_req), 32'(vecs[i].expReq));
            checkOutput($sformatf("v%0d.valid", i), 32'(instr_valid), 32'(vecs[i].expValid));
            checkOutput($sformatf("v%0d.pc", i), pc, vecs[i].expPc);
            checkOutput($sformatf("v%0d.addr", i), imem_addr, vecs[i].expPc);
            checkOutput($sformatf("v%0d.pc_plus4", i), pc_plus4, vecs[i].expPc + 32'd4);
            checkOutput($sformatf("v%0d.instr", i), instr, vecs[i].expInstr);
        end

        // Asynchronous reset in the middle of a REQ at pc 0x3004.
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #2;
        checkOutput("rst1.req", 32'(imem_req), 32'h0);
        checkOutput("rst1.pc", pc, 32'h0000_3000);
        tick();
        rst = 1'b0;
        tick();
        applyStimulus(1'b1, 32'h2001_0005, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("rst2.valid", 32'(instr_valid), 32'h1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("rst2.req", 32'(imem_req), 32'h1);
        checkOutput("rst2.addr", imem_addr, 32'h0000_3004);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst2.req_drop", 32'(imem_req), 32'h0);
        checkOutput("rst2.pc", pc, 32'h0000_3000);
        checkOutput("rst2.valid_low", 32'(instr_valid), 32'h0);
        checkOutput("rst2.instr", instr, 32'h0);
        applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        checkOutput("rst2.idle_req", 32'(imem_req), 32'h0);
        tick();
        checkOutput("late_ack.req", 32'(imem_req), 32'h1);
        checkOutput("late_ack.addr", imem_addr, 32'h0000_3000);
        checkOutput("late_ack.instr", instr, 32'h0);
        checkOutput("late_ack.valid", 32'(instr_valid), 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("refetch.wait_req", 32'(imem_req), 32'h1);
        applyStimulus(1'b1, 32'h3C01_1001, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("refetch.valid", 32'(instr_valid), 32'h1);
        checkOutput("refetch.instr", instr, 32'h3C01_1001);
        checkOutput("refetch.pc", pc, 32'h0000_3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
